// File: rtl/ctl_diag_seq.sv
// ctl_diag_seq: diagnostic-function sequencer for the EBOX CTL board.
//
// Accepts one front-end diagnostic request at a time and latches the 7-bit
// function code. It then runs a setup/strobe/hold sequence that drives the
// CTL diagnostic strobes and the EBUS transceiver enables, and acknowledges
// completion. Read functions (code 100-177) also wait for the addressed EBUS
// responder, with a timeout.
//
// Ports:
//   clk            system clock, all state on the rising edge
//   CROBAR         asynchronous active-high reset
//   fnReq          request level, held by the front end until fnAck is seen
//   fnCode[0:6]    function code (bit 0 is the MSB, so fnCode[0] marks a read)
//   ebusXferAck    EBUS responder done (read functions only)
//   fnAck          completion level, held until fnReq drops
//   fnTimeout      read aborted by timeout, valid while fnAck is high
//   CTL_DIAG_DIAG  latched function code
//   CTL_DIAG_READ  read function in progress
//   CTL_DIAG_STROBE and CTL_DIAG_* decodes   one-cycle function strobes
//   CTL_EBUS_E_TO_T_EN / CTL_EBUS_T_TO_E_EN  transceiver direction enables
//   CTL_EBUS_XFER  read transfer pending on the EBUS
module ctl_diag_seq #(
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       CROBAR,
  input  logic       fnReq,
  input  logic [0:6] fnCode,
  input  logic       ebusXferAck,
  output logic       fnAck,
  output logic       fnTimeout,
  output logic [0:6] CTL_DIAG_DIAG,
  output logic       CTL_DIAG_READ,
  output logic       CTL_DIAG_STROBE,
  output logic       CTL_DIAG_CTL_FUNC_00x,
  output logic       CTL_DIAG_LD_FUNC_04x,
  output logic       CTL_DIAG_LOAD_FUNC_06x,
  output logic       CTL_DIAG_LOAD_FUNC_07x,
  output logic       CTL_DIAG_LOAD_FUNC_072,
  output logic       CTL_DIAG_LD_FUNC_073,
  output logic       CTL_DIAG_LD_FUNC_074,
  output logic       CTL_DIAG_SYNC_FUNC_075,
  output logic       CTL_DIAG_LD_FUNC_076,
  output logic       CTL_DIAG_READ_FUNC_11x,
  output logic       CTL_DIAG_READ_FUNC_12x,
  output logic       CTL_DIAG_READ_FUNC_13x,
  output logic       CTL_DIAG_READ_FUNC_14x,
  output logic       CTL_DIAG_LD_EBUS_REG,
  output logic       CTL_DIAG_AR_LOAD,
  output logic       CTL_EBUS_E_TO_T_EN,
  output logic       CTL_EBUS_T_TO_E_EN,
  output logic       CTL_EBUS_XFER
);

  typedef enum logic [2:0] {
    IDLE, LATCH, SETUP, STROBE, WAIT_XFER, HOLD, ACK
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       tflag;

  // Numeric view of the latched code: MSB is CTL_DIAG_DIAG[0].
  logic [6:0] code_v;
  assign code_v = CTL_DIAG_DIAG;

  logic d_00x, d_04x, d_06x, d_07x, d_072, d_073, d_074, d_075, d_076;
  logic d_11x, d_12x, d_13x, d_14x, d_ldeb, d_ar;

  // Decode of the latched code; only sampled into the strobe registers on
  // entry to STROBE, so it never reaches an output combinationally.
  always_comb begin
    d_00x = 1'b0; d_04x = 1'b0; d_06x = 1'b0; d_07x = 1'b0;
    d_072 = 1'b0; d_073 = 1'b0; d_074 = 1'b0; d_075 = 1'b0; d_076 = 1'b0;
    d_11x = 1'b0; d_12x = 1'b0; d_13x = 1'b0; d_14x = 1'b0;
    d_ldeb = 1'b0; d_ar = 1'b0;
    if (!code_v[6]) begin
      d_ldeb = 1'b1;
      case (code_v[5:3])
        3'd0, 3'd1, 3'd2, 3'd3: d_00x = 1'b1;
        3'd4, 3'd5:             d_04x = 1'b1;
        3'd6:                   d_06x = 1'b1;
        default: begin
          d_07x = 1'b1;
          d_072 = (code_v[2:0] == 3'd2);
          d_073 = (code_v[2:0] == 3'd3);
          d_074 = (code_v[2:0] == 3'd4);
          d_075 = (code_v[2:0] == 3'd5);
          d_076 = (code_v[2:0] == 3'd6);
          d_ar  = (code_v[2:0] == 3'd7);
        end
      endcase
    end else begin
      case (code_v[5:3])
        3'd1:    d_11x = 1'b1;
        3'd2:    d_12x = 1'b1;
        3'd3:    d_13x = 1'b1;
        3'd4:    d_14x = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state                  <= IDLE;
      cnt                    <= '0;
      tflag                  <= 1'b0;
      fnAck                  <= 1'b0;
      fnTimeout              <= 1'b0;
      CTL_DIAG_DIAG          <= '0;
      CTL_DIAG_READ          <= 1'b0;
      CTL_DIAG_STROBE        <= 1'b0;
      CTL_DIAG_CTL_FUNC_00x  <= 1'b0;
      CTL_DIAG_LD_FUNC_04x   <= 1'b0;
      CTL_DIAG_LOAD_FUNC_06x <= 1'b0;
      CTL_DIAG_LOAD_FUNC_07x <= 1'b0;
      CTL_DIAG_LOAD_FUNC_072 <= 1'b0;
      CTL_DIAG_LD_FUNC_073   <= 1'b0;
      CTL_DIAG_LD_FUNC_074   <= 1'b0;
      CTL_DIAG_SYNC_FUNC_075 <= 1'b0;
      CTL_DIAG_LD_FUNC_076   <= 1'b0;
      CTL_DIAG_READ_FUNC_11x <= 1'b0;
      CTL_DIAG_READ_FUNC_12x <= 1'b0;
      CTL_DIAG_READ_FUNC_13x <= 1'b0;
      CTL_DIAG_READ_FUNC_14x <= 1'b0;
      CTL_DIAG_LD_EBUS_REG   <= 1'b0;
      CTL_DIAG_AR_LOAD       <= 1'b0;
      CTL_EBUS_E_TO_T_EN     <= 1'b0;
      CTL_EBUS_T_TO_E_EN     <= 1'b0;
      CTL_EBUS_XFER          <= 1'b0;
    end else begin
      // Strobes are one-cycle pulses: cleared every cycle unless re-fired.
      CTL_DIAG_STROBE        <= 1'b0;
      CTL_DIAG_CTL_FUNC_00x  <= 1'b0;
      CTL_DIAG_LD_FUNC_04x   <= 1'b0;
      CTL_DIAG_LOAD_FUNC_06x <= 1'b0;
      CTL_DIAG_LOAD_FUNC_07x <= 1'b0;
      CTL_DIAG_LOAD_FUNC_072 <= 1'b0;
      CTL_DIAG_LD_FUNC_073   <= 1'b0;
      CTL_DIAG_LD_FUNC_074   <= 1'b0;
      CTL_DIAG_SYNC_FUNC_075 <= 1'b0;
      CTL_DIAG_LD_FUNC_076   <= 1'b0;
      CTL_DIAG_READ_FUNC_11x <= 1'b0;
      CTL_DIAG_READ_FUNC_12x <= 1'b0;
      CTL_DIAG_READ_FUNC_13x <= 1'b0;
      CTL_DIAG_READ_FUNC_14x <= 1'b0;
      CTL_DIAG_LD_EBUS_REG   <= 1'b0;
      CTL_DIAG_AR_LOAD       <= 1'b0;

      case (state)
        IDLE: begin
          if (fnReq) begin
            // Enables and READ are registered on LATCH entry so they are
            // already valid during the LATCH cycle.
            CTL_DIAG_DIAG      <= fnCode;
            CTL_DIAG_READ      <= fnCode[0];
            CTL_EBUS_E_TO_T_EN <= ~fnCode[0];
            CTL_EBUS_T_TO_E_EN <= fnCode[0];
            state              <= LATCH;
          end
        end

        LATCH: begin
          cnt   <= '0;
          state <= SETUP;
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            CTL_DIAG_STROBE        <= 1'b1;
            CTL_DIAG_CTL_FUNC_00x  <= d_00x;
            CTL_DIAG_LD_FUNC_04x   <= d_04x;
            CTL_DIAG_LOAD_FUNC_06x <= d_06x;
            CTL_DIAG_LOAD_FUNC_07x <= d_07x;
            CTL_DIAG_LOAD_FUNC_072 <= d_072;
            CTL_DIAG_LD_FUNC_073   <= d_073;
            CTL_DIAG_LD_FUNC_074   <= d_074;
            CTL_DIAG_SYNC_FUNC_075 <= d_075;
            CTL_DIAG_LD_FUNC_076   <= d_076;
            CTL_DIAG_READ_FUNC_11x <= d_11x;
            CTL_DIAG_READ_FUNC_12x <= d_12x;
            CTL_DIAG_READ_FUNC_13x <= d_13x;
            CTL_DIAG_READ_FUNC_14x <= d_14x;
            CTL_DIAG_LD_EBUS_REG   <= d_ldeb;
            CTL_DIAG_AR_LOAD       <= d_ar;
            state                  <= STROBE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        STROBE: begin
          cnt <= '0;
          if (CTL_DIAG_READ) begin
            CTL_EBUS_XFER <= 1'b1;
            state         <= WAIT_XFER;
          end else begin
            state <= HOLD;
          end
        end

        WAIT_XFER: begin
          // A responder ack in the final counted cycle takes priority over
          // the timeout.
          if (ebusXferAck) begin
            CTL_EBUS_XFER <= 1'b0;
            cnt           <= '0;
            state         <= HOLD;
          end else if (cnt == TO_LAST) begin
            CTL_EBUS_XFER <= 1'b0;
            tflag         <= 1'b1;
            cnt           <= '0;
            state         <= HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        HOLD: begin
          if (cnt == HOLD_LAST) begin
            CTL_EBUS_E_TO_T_EN <= 1'b0;
            CTL_EBUS_T_TO_E_EN <= 1'b0;
            CTL_DIAG_READ      <= 1'b0;
            fnAck              <= 1'b1;
            fnTimeout          <= tflag;
            state              <= ACK;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ACK: begin
          if (!fnReq) begin
            fnAck     <= 1'b0;
            fnTimeout <= 1'b0;
            tflag     <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ctl_diag_seq.md
# ctl_diag_seq

Diagnostic-function sequencer for the EBOX CTL board. Accepts one diagnostic function request at a time from the front-end EBUS interface and latches the 7-bit function code. It then runs a fixed setup/strobe/hold sequence that drives the CTL diagnostic strobes and EBUS transceiver enables, and acknowledges completion. Read functions additionally wait, with a timeout, for the addressed EBUS responder.

## Interface
Parameters:
- SETUP_CYC, 2, cycles the transceiver enable is held before the strobe (≥1)
- HOLD_CYC, 2, cycles the enable is held after the strobe or transfer (≥1)
- TIMEOUT, 255, maximum WAIT_XFER cycles before abort (1..255, 8-bit counter)

Ports:
- clk  in  1  system clock, all state on rising edge
- CROBAR  in  1  reset, asynchronous, active-high
- fnReq  in  1  front-end request level, held until fnAck seen
- fnCode  in  7 [0:6]  function code (octal 000-177), sampled on acceptance
- ebusXferAck  in  1  EBUS responder done (read functions)
- fnAck  out  1  completion, level
- fnTimeout  out  1  read aborted, valid while fnAck high
- CTL_DIAG_DIAG  out  7 [0:6]  latched function code
- CTL_DIAG_READ  out  1  read function in progress
- CTL_DIAG_STROBE  out  1  one-cycle function strobe
- CTL_DIAG_CTL_FUNC_00x, CTL_DIAG_LD_FUNC_04x, CTL_DIAG_LOAD_FUNC_06x, CTL_DIAG_LOAD_FUNC_07x, CTL_DIAG_LOAD_FUNC_072, CTL_DIAG_LD_FUNC_073, CTL_DIAG_LD_FUNC_074, CTL_DIAG_SYNC_FUNC_075, CTL_DIAG_LD_FUNC_076  out  1 each  decoded write strobes
- CTL_DIAG_READ_FUNC_11x..14x  out  1 each  decoded read strobes
- CTL_DIAG_LD_EBUS_REG  out  1  write-data load pulse
- CTL_DIAG_AR_LOAD  out  1  AR load pulse (code 077)
- CTL_EBUS_E_TO_T_EN  out  1  EBUS→internal enable (writes)
- CTL_EBUS_T_TO_E_EN  out  1  internal→EBUS enable (reads)
- CTL_EBUS_XFER  out  1  read transfer pending on EBUS

## Operation
- States: IDLE, LATCH, SETUP, STROBE, WAIT_XFER, HOLD, ACK.
- IDLE: when fnReq=1, capture fnCode into CTL_DIAG_DIAG, set rd=fnCode[0], go to LATCH.
- LATCH (1 cycle): assert the direction enable, E_TO_T_EN if rd=0, T_TO_E_EN if rd=1. CTL_DIAG_READ=rd. Go to SETUP.
- SETUP: SETUP_CYC cycles, then STROBE.
- STROBE (1 cycle): CTL_DIAG_STROBE=1 plus exactly the decoded pulses for the latched code.
  - 000-037: CTL_FUNC_00x. 040-057: LD_FUNC_04x. 060-067: LOAD_FUNC_06x.
  - 070-077: LOAD_FUNC_07x, plus the matching 072/073/074/075/076 strobe. 077 also asserts AR_LOAD.
  - Every write (000-077) also asserts LD_EBUS_REG.
  - 110-117/120-127/130-137/140-147: READ_FUNC_11x/12x/13x/14x. Other read codes assert no decode.
  - Writes go to HOLD. Reads go to WAIT_XFER and clear the timeout counter.
- WAIT_XFER: CTL_EBUS_XFER=1 and the counter increments each cycle.
  - ebusXferAck=1: go to HOLD.
  - Counter reaches TIMEOUT without ack: set the timeout flag and go to HOLD. ebusXferAck arriving in that same cycle wins and no timeout is flagged.
- HOLD: HOLD_CYC cycles with the enable still asserted, then ACK.
- ACK: both enables and CTL_DIAG_READ deasserted. fnAck=1 and fnTimeout=flag are held until fnReq=0, then go to IDLE and clear the flag. A held-high fnReq never starts a second function.
- Invariants:
  - E_TO_T_EN and T_TO_E_EN are never both high.
  - Enables change only on the LATCH entry and ACK entry transitions.
  - CTL_DIAG_DIAG is stable from LATCH through ACK.

## Timing
- Reset: every output is 0, CTL_DIAG_DIAG=0, state=IDLE, counters=0, flag=0. CROBAR mid-sequence aborts immediately with no ack and no strobe.
- fnReq sampled high in IDLE at edge 0 (defaults):
  - LATCH at cycle 1, SETUP at cycles 2-3, STROBE at cycle 4.
  - Writes: HOLD at cycles 5-6, fnAck rises at cycle 7.
  - Reads: if ebusXferAck is sampled at cycle n≥5, HOLD runs n+1..n+2 and fnAck rises at n+3.
  - Read timeout: fnAck rises at cycle 5+TIMEOUT+HOLD_CYC.
- Write latency = 3+SETUP_CYC+HOLD_CYC cycles. All decoded strobes are exactly one cycle wide and coincide with CTL_DIAG_STROBE.
- ebusXferAck outside WAIT_XFER is ignored.
- Outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Test plan
- Write 075, default params -> E_TO_T_EN high cycles 1-6; at cycle 4 STROBE, LOAD_FUNC_07x, SYNC_FUNC_075 and LD_EBUS_REG are high and no other strobe is; fnAck at cycle 7 holds until fnReq drops.
- Write 077 -> AR_LOAD and LOAD_FUNC_07x pulse at cycle 4; T_TO_E_EN stays 0 throughout.
- Read 123 with ebusXferAck at cycle 9 -> READ_FUNC_12x at cycle 4; XFER high cycles 5-9; fnAck at cycle 12 with fnTimeout=0.
- Read 100 with TIMEOUT=4 and no responder -> no decode strobe; XFER high for 4 cycles; fnAck with fnTimeout=1; the next request shows fnTimeout=0.
- fnReq held high after ack, then dropped and re-raised with 040 -> exactly one 040 sequence and no repeat while fnReq stays high.
- CROBAR pulsed at cycle 3 of a read -> all outputs 0 at once, no STROBE or ack; the next request runs a full normal sequence.
